// File: rtl/pixel_arb_pkg.sv
// Shared types and the round-robin helper for the pixel stream arbiter.
package pixel_arb_pkg;

  // Widest channel count the round-robin helper handles.
  localparam int MAX_CH = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_e;

  // One-hot grant for the first requester strictly after 'last', scanning
  // upward and wrapping at num_ch. Returns all-zero when nobody requests.
  function automatic logic [MAX_CH-1:0] next_rr(
    input logic [MAX_CH-1:0] req,
    input int                last,
    input int                num_ch
  );
    logic [MAX_CH-1:0] gnt;
    logic              found;
    logic              valid;
    logic              take;
    int                idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_CH; k++) begin
      valid    = (k <= num_ch);
      idx      = valid ? ((last + k) % num_ch) : 0;
      take     = valid & req[idx] & ~found;
      gnt[idx] = gnt[idx] | take;
      found    = found | take;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous FIFO buffering one non-stallable pixel source.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module pix_fifo #(
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [PIX_W-1:0] data_i,
  input  logic             pop_i,
  output logic [PIX_W-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [PIX_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_s, rd_s;

  assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == (AW+1)'(0));
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping for accepted pushes and pops.
  always_comb begin
    wr_s     = push_i & (~full_o | pop_i);
    rd_s     = pop_i & ~empty_o;
    wr_ptr_d = wr_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = rd_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({wr_s, rd_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write; data needs no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer/occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pixel_stream_arbiter.sv
// Merges NUM_CH non-stallable pixel streams into one. A channel owns the output
// for a whole frame of FRAME_PIX pixels, then the arbiter re-arbitrates.
module pixel_stream_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_PIX  = 291600,
  parameter int CNT_W      = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*PIX_W-1:0]   pix_i,
  input  logic [NUM_CH-1:0]         pix_en_i,
  input  logic                      force_en_i,
  input  logic [$clog2(NUM_CH)-1:0] force_ch_i,
  input  logic                      clr_ovf_i,
  output logic [PIX_W-1:0]          pixel_o,
  output logic                      pixel_en_o,
  output logic                      frame_done_o,
  output logic [NUM_CH-1:0]         grant_o,
  output logic                      busy_o,
  output logic [NUM_CH-1:0]         ovf_o
);

  localparam int                CH_W     = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_PIX - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_CH-1:0]  grant_q, grant_d;
  logic [CH_W-1:0]    rr_last_q, rr_last_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [PIX_W-1:0]   pixel_q, pixel_d;
  logic               pixel_en_q, pixel_en_d;
  logic               frame_done_q, frame_done_d;
  logic [NUM_CH-1:0]  ovf_q, ovf_d;

  logic [NUM_CH-1:0]  full_s, empty_s, pop_s, ovf_evt_s, force_gnt_s;
  logic [PIX_W-1:0]   fifo_dout_s [NUM_CH];
  logic [MAX_CH-1:0]  req_full_s, rr_full_s;
  logic               rr_found_s, force_ok_s, pop_any_s;
  logic [CH_W-1:0]    gnt_idx_s;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
    pix_fifo #(
      .PIX_W      (PIX_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (pix_en_i[c]),
      .data_i  (pix_i[c*PIX_W +: PIX_W]),
      .pop_i   (pop_s[c]),
      .data_o  (fifo_dout_s[c]),
      .full_o  (full_s[c]),
      .empty_o (empty_s[c])
    );
  end

  // Request decode: granted-channel index, pops, overflow events, candidates.
  always_comb begin
    gnt_idx_s   = '0;
    force_gnt_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      gnt_idx_s      = gnt_idx_s | (grant_q[c] ? CH_W'(c) : CH_W'(0));
      force_gnt_s[c] = (int'(force_ch_i) == c);
    end
    pop_s      = (state_q == STREAM) ? (grant_q & ~empty_s) : '0;
    pop_any_s  = |pop_s;
    ovf_evt_s  = pix_en_i & full_s & ~pop_s;
    req_full_s = '0;
    req_full_s[NUM_CH-1:0] = ~empty_s;
    rr_full_s  = next_rr(req_full_s, int'(rr_last_q), NUM_CH);
    rr_found_s = |rr_full_s;
    force_ok_s = force_en_i & (int'(force_ch_i) < NUM_CH);
  end

  // Frame FSM next state plus output-register and overflow next values.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_last_d    = rr_last_q;
    pix_cnt_d    = pix_cnt_q;
    pixel_d      = pixel_q;
    pixel_en_d   = 1'b0;
    frame_done_d = 1'b0;
    ovf_d        = clr_ovf_i ? '0 : (ovf_q | ovf_evt_s);
    case (state_q)
      IDLE: begin
        if (force_ok_s) begin
          if (|(force_gnt_s & ~empty_s)) begin
            grant_d = force_gnt_s;
            state_d = STREAM;
          end else begin
            grant_d = '0;
          end
        end else if (rr_found_s) begin
          grant_d = rr_full_s[NUM_CH-1:0];
          state_d = STREAM;
        end else begin
          grant_d = '0;
        end
      end
      STREAM: begin
        if (pop_any_s) begin
          pixel_d    = fifo_dout_s[gnt_idx_s];
          pixel_en_d = 1'b1;
          if (pix_cnt_q == LAST_CNT) begin
            frame_done_d = 1'b1;
            pix_cnt_d    = '0;
            rr_last_d    = gnt_idx_s;
            grant_d      = '0;
            state_d      = IDLE;
          end else begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
          end
        end else begin
          pixel_en_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, counters, output register and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_last_q    <= CH_W'(NUM_CH - 1);
      pix_cnt_q    <= '0;
      pixel_q      <= '0;
      pixel_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_last_q    <= rr_last_d;
      pix_cnt_q    <= pix_cnt_d;
      pixel_q      <= pixel_d;
      pixel_en_q   <= pixel_en_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign pixel_o      = pixel_q;
  assign pixel_en_o   = pixel_en_q;
  assign frame_done_o = frame_done_q;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q == STREAM);
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_pixel_stream_arbiter.sv
// Bench for pixel_stream_arbiter: directed scenarios plus random traffic,
// checked against a queue-based frame-ownership reference model.
module tb_pixel_stream_arbiter;

  localparam int NUM_CH     = 3;
  localparam int PIX_W      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_PIX  = 16;
  localparam int CNT_W      = 4;

  logic                      clk;
  logic                      rst;
  logic [NUM_CH*PIX_W-1:0]   pix_i;
  logic [NUM_CH-1:0]         pix_en_i;
  logic                      force_en_i;
  logic [$clog2(NUM_CH)-1:0] force_ch_i;
  logic                      clr_ovf_i;
  logic [PIX_W-1:0]          pixel_o;
  logic                      pixel_en_o;
  logic                      frame_done_o;
  logic [NUM_CH-1:0]         grant_o;
  logic                      busy_o;
  logic [NUM_CH-1:0]         ovf_o;

  pixel_stream_arbiter #(
    .NUM_CH     (NUM_CH),
    .PIX_W      (PIX_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FRAME_PIX  (FRAME_PIX),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_i        (pix_i),
    .pix_en_i     (pix_en_i),
    .force_en_i   (force_en_i),
    .force_ch_i   (force_ch_i),
    .clr_ovf_i    (clr_ovf_i),
    .pixel_o      (pixel_o),
    .pixel_en_o   (pixel_en_o),
    .frame_done_o (frame_done_o),
    .grant_o      (grant_o),
    .busy_o       (busy_o),
    .ovf_o        (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  // Reference model: per-channel pixel queues and the current frame owner.
  logic [PIX_W-1:0]  mq [NUM_CH][$];
  logic [PIX_W:0]    sb [$];          // {frame_done, pixel}
  int                m_owner = -1;
  int                m_cnt   = 0;
  int                m_rr    = NUM_CH - 1;
  logic [NUM_CH-1:0] m_ovf   = '0;
  logic              m_en    = 1'b0;
  logic              m_done  = 1'b0;
  logic [PIX_W-1:0]  m_pix   = '0;

  function automatic bit any_pending();
    for (int c = 0; c < NUM_CH; c++) if (mq[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [PIX_W-1:0] px;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      sb.delete();
      m_owner = -1; m_cnt = 0; m_rr = NUM_CH - 1;
      m_ovf = '0; m_en = 1'b0; m_done = 1'b0; m_pix = '0;
      return;
    end
    m_en = 1'b0;
    m_done = 1'b0;
    if (m_owner >= 0) begin
      if (mq[m_owner].size() > 0) begin
        px     = mq[m_owner].pop_front();
        m_pix  = px;
        m_en   = 1'b1;
        m_done = (m_cnt == FRAME_PIX - 1);
        sb.push_back({m_done, px});
        if (m_done) begin
          m_rr = m_owner; m_owner = -1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end else if (force_en_i && int'(force_ch_i) < NUM_CH) begin
      if (mq[force_ch_i].size() > 0) m_owner = int'(force_ch_i);
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        int c = (m_rr + k) % NUM_CH;
        if (m_owner < 0 && mq[c].size() > 0) m_owner = c;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (pix_en_i[c]) begin
        if (mq[c].size() < FIFO_DEPTH) mq[c].push_back(pix_i[c*PIX_W +: PIX_W]);
        else m_ovf[c] = 1'b1;
      end
    end
    if (clr_ovf_i) m_ovf = '0;
  endtask

  always @(posedge clk) model_step();

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: per-cycle output comparison plus scoreboard pop on every pixel.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [PIX_W:0] e;
      chk("pixel_en", 32'(pixel_en_o), 32'(m_en));
      chk("frame_done", 32'(frame_done_o), 32'(m_done));
      chk("pixel_hold", 32'(pixel_o), 32'(m_pix));
      chk("grant", 32'(grant_o), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("busy", 32'(busy_o), 32'(m_owner >= 0));
      chk("ovf", 32'(ovf_o), 32'(m_ovf));
      if (pixel_en_o) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty at %0t: got pixel %0h expected none", $time, pixel_o);
        end else begin
          e = sb.pop_front();
          chk("sb_pixel", 32'(pixel_o), 32'(e[PIX_W-1:0]));
          chk("sb_done", 32'(frame_done_o), 32'(e[PIX_W]));
        end
      end
    end
  end

  task automatic step(input logic [NUM_CH-1:0] en, input logic [NUM_CH*PIX_W-1:0] px);
    pix_en_i = en;
    pix_i    = px;
    @(negedge clk);
    pix_en_i = '0;
  endtask

  // Feed the owning channel until every frame closes and all queues drain.
  task automatic finish_frames(input int budget);
    int n = 0;
    while ((m_owner >= 0 || any_pending()) && n < budget) begin
      pix_en_i = '0;
      if (m_owner >= 0 && mq[m_owner].size() == 0) begin
        pix_en_i[m_owner] = 1'b1;
        pix_i = {NUM_CH{8'($urandom)}};
      end
      @(negedge clk);
      n++;
    end
    pix_en_i = '0;
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles expected under %0d", n, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; pix_i = '0; pix_en_i = '0;
    force_en_i = 1'b0; force_ch_i = '0; clr_ovf_i = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    step('0, '0);
    rst = 1'b0;
    step('0, '0);

    // 1: ch1 alone, one full frame back-to-back
    for (int i = 0; i < 16; i++) step(3'b010, {8'h00, 8'(8'h10 + i), 8'h00});
    finish_frames(200);

    // 2: ch0 and ch2 together, one pixel every 4 cycles
    for (int i = 0; i < 16; i++) begin
      step(3'b101, {8'(8'h20 + i), 8'h00, 8'(8'h30 + i)});
      repeat (3) step('0, '0);
    end
    finish_frames(300);

    // 3: forced ch2 while ch0 and ch2 both pending
    force_en_i = 1'b1; force_ch_i = 2'd2;
    step(3'b101, {8'hA0, 8'h00, 8'hB0});
    step('0, '0);
    step('0, '0);
    force_en_i = 1'b0;
    finish_frames(300);

    // 4: ch1 bursts 6 pixels while ch0 owns the output, then clear overflow
    step(3'b001, {16'h0000, 8'h40});
    step('0, '0);
    step('0, '0);
    for (int i = 0; i < 6; i++) step(3'b010, {8'h00, 8'(8'h50 + i), 8'h00});
    finish_frames(300);
    clr_ovf_i = 1'b1;
    step('0, '0);
    clr_ovf_i = 1'b0;
    step('0, '0);

    // 5: reset in the middle of a ch0 frame, then a fresh frame
    n = 0;
    while (m_cnt != 7 && n < 40) begin
      step(3'b001, {16'h0000, 8'(8'h60 + n)});
      n++;
    end
    rst = 1'b1;
    step('0, '0);
    rst = 1'b0;
    step('0, '0);
    for (int i = 0; i < 16; i++) step(3'b001, {16'h0000, 8'(8'hC0 + i)});
    finish_frames(200);

    // 6: ch0 full at the start of its frame, push and pop together
    step(3'b010, {8'h00, 8'h70, 8'h00});
    step('0, '0);
    step('0, '0);
    for (int i = 0; i < 4; i++) step(3'b001, {16'h0000, 8'(8'h80 + i)});
    for (int i = 0; i < 15; i++) step(3'b010, {8'h00, 8'(8'h71 + i), 8'h00});
    n = 0;
    while (!(m_owner == 0 && mq[0].size() == FIFO_DEPTH) && n < 20) begin
      step('0, '0);
      n++;
    end
    for (int i = 0; i < 8; i++) step(3'b001, {16'h0000, 8'(8'h84 + i)});
    finish_frames(200);

    // Random traffic with occasional force, clear and reset
    for (int i = 0; i < 1500; i++) begin
      force_en_i = ($urandom_range(0, 7) == 0);
      force_ch_i = 2'($urandom_range(0, 3));
      clr_ovf_i  = ($urandom_range(0, 31) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      step({($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0)}, 24'($urandom));
    end
    force_en_i = 1'b0; clr_ovf_i = 1'b0; rst = 1'b0;
    finish_frames(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
